// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_arbiter
// Brief    : Round-robin arbiter sharing one 16-op 4-bit ALU between two
//            valid/ready requesters; holds each result until the owner accepts.
// Revision : 1.0 - initial release
// ============================================================================
module alu_req_arbiter #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [3:0]         req0_op,
  input  logic [3:0]         req0_a,
  input  logic [3:0]         req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [3:0]         req1_op,
  input  logic [3:0]         req1_a,
  input  logic [3:0]         req1_b,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [7:0]         rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [3:0]           a_q, a_d;
  logic [3:0]           b_q, b_d;
  logic                 owner_q, owner_d;
  logic                 last_grant_q, last_grant_d;
  logic [7:0]           rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [COUNT_W-1:0]   op_count_q, op_count_d;

  logic                 pick1;
  logic                 idle;
  logic                 rsp_hs;
  logic [7:0]           alu_res;
  logic                 alu_err;
  logic [7:0]           a_ext, b_ext;
  logic                 a_nz, b_nz;

  // Requester 1 wins when alone, or on contention when requester 0 went last.
  assign pick1      = req1_valid & (~req0_valid | ~last_grant_q);
  assign idle       = (state_q == IDLE);
  assign req0_ready = idle & ~rst & req0_valid & ~pick1;
  assign req1_ready = idle & ~rst & pick1;

  assign rsp0_valid = (state_q == RESP) & ~owner_q;
  assign rsp1_valid = (state_q == RESP) & owner_q;
  assign rsp_hs     = owner_q ? rsp1_ready : rsp0_ready;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = ~idle;
  assign op_count   = op_count_q;

  assign a_ext = {4'd0, a_q};
  assign b_ext = {4'd0, b_q};
  assign a_nz  = |a_q;
  assign b_nz  = |b_q;

  always_comb begin
    alu_res = 8'd0;
    alu_err = 1'b0;
    case (op_q)
      4'd0:  alu_res = a_ext + b_ext;
      4'd1:  alu_res = a_ext - b_ext;
      4'd2:  alu_res = a_ext * b_ext;
      4'd3:  begin
        if (b_nz) alu_res = a_ext / b_ext;
        else      alu_err = 1'b1;
      end
      4'd4:  begin
        if (b_nz) alu_res = a_ext % b_ext;
        else      alu_err = 1'b1;
      end
      4'd5:  alu_res = {7'd0, a_nz & b_nz};
      4'd6:  alu_res = {7'd0, a_nz | b_nz};
      4'd7:  alu_res = a_ext ^ b_ext;
      4'd8:  alu_res = ~(a_ext ^ b_ext);
      4'd9:  alu_res = {7'd0, ~(a_nz & b_nz)};
      4'd10: alu_res = {7'd0, ~(a_nz | b_nz)};
      4'd11: alu_res = {7'd0, ~a_nz};
      4'd12: alu_res = {7'd0, ~b_nz};
      4'd13: alu_res = {a_ext[6:0], 1'b0};
      4'd14: alu_res = {7'd0, a_ext < b_ext};
      4'd15: alu_res = {7'd0, a_ext > b_ext};
      default: alu_res = 8'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    op_count_d   = op_count_q;
    case (state_q)
      IDLE: begin
        if (req0_ready | req1_ready) begin
          op_d         = pick1 ? req1_op : req0_op;
          a_d          = pick1 ? req1_a  : req0_a;
          b_d          = pick1 ? req1_b  : req0_b;
          owner_d      = pick1;
          last_grant_d = pick1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = alu_res;
        rsp_err_d  = alu_err;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          op_count_d = op_count_q + COUNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= 4'd0;
      a_q          <= 4'd0;
      b_q          <= 4'd0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_data_q   <= 8'd0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      op_count_q   <= op_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_req_arbiter
// Brief    : Directed self-checking bench for alu_req_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_req_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_op, req0_a, req0_b;
  logic [3:0] req1_op, req1_a, req1_b;
  logic       rsp0_ready, rsp1_ready;

  wire        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  wire [7:0]  rsp_data;
  wire        rsp_err, busy;
  wire [7:0]  op_count;

  wire        w2_req0_ready, w2_req1_ready, w2_rsp0_valid, w2_rsp1_valid;
  wire [7:0]  w2_rsp_data;
  wire        w2_rsp_err, w2_busy;
  wire [1:0]  w2_op_count;

  int checks = 0;
  int errors = 0;

  alu_req_arbiter #(.COUNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
  );

  // Narrow-counter instance driven in lockstep to exercise wrap-around.
  alu_req_arbiter #(.COUNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(w2_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(w2_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(w2_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(w2_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(w2_rsp_data), .rsp_err(w2_rsp_err), .busy(w2_busy),
    .op_count(w2_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a falling edge with the DUT idle.
  task automatic do_op(input int r, input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [7:0] ed, input logic ee,
                       input string tag);
    if (r == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    #1;
    chk({tag, "_ready"}, (r == 0) ? req0_ready : req1_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({tag, "_exec_busy"}, busy, 1);
    chk({tag, "_exec_novalid"}, (r == 0) ? rsp0_valid : rsp1_valid, 0);
    @(negedge clk);
    chk({tag, "_rsp_valid"}, (r == 0) ? rsp0_valid : rsp1_valid, 1);
    chk({tag, "_rsp_other"}, (r == 0) ? rsp1_valid : rsp0_valid, 0);
    chk({tag, "_data"}, rsp_data, ed);
    chk({tag, "_err"}, rsp_err, ee);
    if (r == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_valid"}, (r == 0) ? rsp0_valid : rsp1_valid, 0);
    chk({tag, "_done_busy"}, busy, 0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = 4'd0; req0_a = 4'd0; req0_b = 4'd0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset state, with requests pending to show ready is suppressed.
    @(negedge clk);
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_op_count", op_count, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Single operations.
    do_op(0, 4'd0,  4'd9,  4'd7,  8'd16,  1'b0, "add");
    do_op(0, 4'd2,  4'd15, 4'd15, 8'd225, 1'b0, "mul");
    do_op(1, 4'd1,  4'd3,  4'd5,  8'hFE,  1'b0, "sub");
    do_op(0, 4'd13, 4'd15, 4'd0,  8'd30,  1'b0, "shl");
    do_op(1, 4'd3,  4'd6,  4'd0,  8'd0,   1'b1, "div0");
    chk("count5", op_count, 5);
    chk("count_wrap", w2_op_count, 1);
    do_op(0, 4'd4,  4'd13, 4'd4,  8'd1,   1'b0, "mod");
    do_op(1, 4'd3,  4'd13, 4'd4,  8'd3,   1'b0, "div");
    do_op(0, 4'd8,  4'd0,  4'd0,  8'hFF,  1'b0, "xnor");
    do_op(1, 4'd14, 4'd3,  4'd5,  8'd1,   1'b0, "lt");
    do_op(0, 4'd10, 4'd0,  4'd0,  8'd1,   1'b0, "nor");
    do_op(1, 4'd15, 4'd9,  4'd2,  8'd1,   1'b0, "gt");
    do_op(0, 4'd9,  4'd5,  4'd0,  8'd1,   1'b0, "nand");
    do_op(1, 4'd4,  4'd7,  4'd0,  8'd0,   1'b1, "mod0");
    chk("count13", op_count, 13);

    // Contention from reset: grants alternate starting with requester 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 4'd1; req0_b = 4'd2;
    req1_valid = 1'b1; req1_op = 4'd2; req1_a = 4'd3; req1_b = 4'd4;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_req0_ready", req0_ready, (k % 2 == 0) ? 1 : 0);
      chk("cont_req1_ready", req1_ready, (k % 2 == 1) ? 1 : 0);
      @(negedge clk);
      @(negedge clk);
      chk("cont_rsp0_valid", rsp0_valid, (k % 2 == 0) ? 1 : 0);
      chk("cont_rsp1_valid", rsp1_valid, (k % 2 == 1) ? 1 : 0);
      chk("cont_data", rsp_data, (k % 2 == 0) ? 3 : 12);
      @(negedge clk);
    end
    chk("cont_count", op_count, 4);

    // Backpressure on requester 1 while requester 0 waits.
    req0_valid = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #1;
    chk("bp_req1_ready", req1_ready, 1);
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 4'd7; req0_a = 4'd5; req0_b = 4'd3;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp1_valid", rsp1_valid, 1);
      chk("bp_rsp_data", rsp_data, 12);
      chk("bp_busy", busy, 1);
      chk("bp_req0_ready", req0_ready, 0);
      chk("bp_req1_ready_hold", req1_ready, 0);
      @(negedge clk);
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1;
    chk("bp_after_req0_ready", req0_ready, 1);
    chk("bp_after_req1_ready", req1_ready, 0);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_req0_rsp_valid", rsp0_valid, 1);
    chk("bp_req0_data", rsp_data, 6);
    chk("bp_count", op_count, 5);
    rsp0_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    rsp0_ready = 1'b0;

    // Reset during EXEC.
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 4'd1; req0_b = 4'd1;
    @(negedge clk);
    req0_valid = 1'b0;
    chk("rexec_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("rexec_busy", busy, 0);
    chk("rexec_rsp_data", rsp_data, 0);
    chk("rexec_count", op_count, 0);
    chk("rexec_rsp0_valid", rsp0_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset during RESP, after requester 0 became last grant.
    req0_valid = 1'b1; req0_op = 4'd3; req0_a = 4'd6; req0_b = 4'd0;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("rresp_valid_before", rsp0_valid, 1);
    chk("rresp_err_before", rsp_err, 1);
    rst = 1'b1;
    #1;
    chk("rresp_rsp0_valid", rsp0_valid, 0);
    chk("rresp_rsp_err", rsp_err, 0);
    chk("rresp_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rresp_grant0", req0_ready, 1);
    chk("rresp_grant1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
